// File: rtl/cgr_hist.sv
// cgr_hist: 64-cell CGR address frequency histogram with a sequential clear
// sweep and a valid/ready dump stream of every cell counter.
module cgr_hist #(
    parameter int CNT_W  = 16,
    parameter int N_ADDR = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [5:0]         addr,
    input  logic               wen_cgr,
    input  logic               clear,
    input  logic               dump_start,
    output logic               busy,
    output logic               drop_flag,
    output logic [CNT_W+5:0]   total_cnt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         out_idx,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DUMP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W+5:0] TOT_ONE = 1;
    localparam logic [5:0]       IDX_ONE = 1;
    localparam logic [5:0]       IDX_MAX = 6'd63;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_clr_entry;
    logic               w_xfer;

    logic               r_in_vld;
    logic [5:0]         r_in_addr;
    logic               r_busy;
    logic               r_drop;
    logic [CNT_W+5:0]   r_total;
    logic [5:0]         r_clr_idx;
    logic               r_out_valid;
    logic [5:0]         r_out_idx;
    logic [CNT_W-1:0]   r_cnt [N_ADDR];

    assign w_xfer      = r_out_valid && out_ready;
    assign w_clr_entry = (w_state_nxt == S_CLEAR) && (r_state != S_CLEAR);

    // state register
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // next-state: clear beats dump_start; CLEAR ignores both requests
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (clear)           w_state_nxt = S_CLEAR;
                else if (dump_start) w_state_nxt = S_DUMP;
            end
            S_CLEAR: begin
                if (r_clr_idx == IDX_MAX) w_state_nxt = S_IDLE;
            end
            S_DUMP: begin
                if (clear)                                w_state_nxt = S_CLEAR;
                else if (w_xfer && r_out_idx == IDX_MAX) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // input stage and status: requests only accepted in IDLE, otherwise dropped
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_in_vld  <= 1'b0;
            r_in_addr <= '0;
            r_busy    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_in_vld  <= (r_state == S_IDLE) && wen_cgr;
            r_in_addr <= addr;
            r_busy    <= (w_state_nxt != S_IDLE);
            if (wen_cgr && r_busy) r_drop <= 1'b1;
            else if (w_clr_entry)  r_drop <= 1'b0;
        end
    end

    // cell counters: saturating increment, clear sweep overrides on the same cell
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N_ADDR; i++) r_cnt[i] <= '0;
        end else begin
            if (r_in_vld && (r_cnt[r_in_addr] != '1))
                r_cnt[r_in_addr] <= r_cnt[r_in_addr] + CNT_ONE;
            if (r_state == S_CLEAR)
                r_cnt[r_clr_idx] <= '0;
        end
    end

    // total of applied increments, including ones absorbed by a saturated cell
    always_ff @(posedge CLK) begin
        if (RST)                             r_total <= '0;
        else if (w_clr_entry)                r_total <= '0;
        else if (r_in_vld && r_total != '1)  r_total <= r_total + TOT_ONE;
    end

    // clear sweep index, one cell per cycle while in CLEAR
    always_ff @(posedge CLK) begin
        if (RST)                     r_clr_idx <= '0;
        else if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + IDX_ONE;
        else                         r_clr_idx <= '0;
    end

    // dump stream: valid follows DUMP state, index advances on each handshake
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            r_out_valid <= (w_state_nxt == S_DUMP);
            if (r_state != S_DUMP) r_out_idx <= '0;
            else if (w_xfer)       r_out_idx <= r_out_idx + IDX_ONE;
        end
    end

    assign busy      = r_busy;
    assign drop_flag = r_drop;
    assign total_cnt = r_total;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_count = r_cnt[r_out_idx];
    assign out_last  = r_out_valid && (r_out_idx == IDX_MAX);

endmodule

// File: tb/tb_cgr_hist.sv
// tb_cgr_hist: randomized stimulus against a cell-count/total reference model.
module tb_cgr_hist;

    localparam int     CNT_W = 16;
    localparam longint CMAX  = (64'd1 << CNT_W) - 1;
    localparam longint TMAX  = (64'd1 << (CNT_W + 6)) - 1;

    logic               CLK = 1'b0;
    logic               RST;
    logic [5:0]         addr;
    logic               wen_cgr;
    logic               clear;
    logic               dump_start;
    logic               busy;
    logic               drop_flag;
    logic [CNT_W+5:0]   total_cnt;
    logic               out_valid;
    logic               out_ready;
    logic [5:0]         out_idx;
    logic [CNT_W-1:0]   out_count;
    logic               out_last;

    cgr_hist #(.CNT_W(CNT_W), .N_ADDR(64)) dut (
        .CLK(CLK), .RST(RST), .addr(addr), .wen_cgr(wen_cgr), .clear(clear),
        .dump_start(dump_start), .busy(busy), .drop_flag(drop_flag),
        .total_cnt(total_cnt), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_count(out_count), .out_last(out_last)
    );

    always #5 CLK = ~CLK;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint mdl_cnt [64];
    longint mdl_tot;
    bit     mdl_drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic mdl_reset;
        for (int i = 0; i < 64; i++) mdl_cnt[i] = 0;
        mdl_tot  = 0;
        mdl_drop = 0;
    endtask

    task automatic mdl_inc(input int a);
        if (mdl_cnt[a] < CMAX) mdl_cnt[a]++;
        if (mdl_tot < TMAX)    mdl_tot++;
    endtask

    // increments while idle; fix_addr < 0 selects random addresses
    task automatic incs(input int n, input int fix_addr, input int dens);
        for (int i = 0; i < n; i++) begin
            wen_cgr = ($urandom_range(0, 99) < dens);
            addr    = (fix_addr < 0) ? 6'($urandom_range(0, 63)) : 6'(fix_addr);
            if (wen_cgr) mdl_inc(int'(addr));
            tick;
        end
        wen_cgr = 0;
        tick;
        tick;
        chk("total_after_incs", total_cnt, mdl_tot);
    endtask

    // rmode: 0 ready always, 1 ready toggles starting low, 2 random ready
    task automatic run_dump(input int rmode, input bit inject, output int vcyc);
        int k;
        k = 0;
        vcyc = 0;
        wen_cgr = 0;
        dump_start = 1;
        tick;
        dump_start = 0;
        for (int c = 0; c < 1000 && k < 64; c++) begin
            if (!out_valid) begin
                chk("dump_valid_high", out_valid, 1);
                break;
            end
            vcyc++;
            chk("dump_idx", out_idx, k);
            chk("dump_count", out_count, mdl_cnt[k]);
            chk("dump_last", out_last, (k == 63));
            case (rmode)
                0:       out_ready = 1;
                1:       out_ready = c[0];
                default: out_ready = $urandom_range(0, 1);
            endcase
            if (inject && $urandom_range(0, 3) == 0) begin
                wen_cgr  = 1;
                addr     = 6'($urandom_range(0, 63));
                mdl_drop = 1;
            end else begin
                wen_cgr = 0;
            end
            if (out_ready) k++;
            tick;
        end
        wen_cgr = 0;
        out_ready = 0;
        chk("dump_xfers", k, 64);
        chk("dump_end_valid", out_valid, 0);
        chk("dump_end_busy", busy, 0);
        chk("drop_flag", drop_flag, mdl_drop);
        chk("total_after_dump", total_cnt, mdl_tot);
    endtask

    // waits out a clear sweep already entered, poking ignored requests into it
    task automatic wait_clear(input bit inject);
        int bc, vhi;
        bc = 0;
        vhi = 0;
        mdl_tot  = 0;
        mdl_drop = 0;
        for (int c = 0; c < 300; c++) begin
            if (!busy) break;
            bc++;
            if (out_valid) vhi++;
            if (inject && $urandom_range(0, 3) == 0) begin
                wen_cgr  = 1;
                addr     = 6'($urandom_range(0, 63));
                mdl_drop = 1;
            end else begin
                wen_cgr = 0;
            end
            dump_start = inject && ($urandom_range(0, 7) == 0);
            clear      = inject && ($urandom_range(0, 7) == 0);
            tick;
        end
        wen_cgr = 0;
        dump_start = 0;
        clear = 0;
        for (int i = 0; i < 64; i++) mdl_cnt[i] = 0;
        chk("clear_busy_cycles", bc, 64);
        chk("clear_valid_cycles", vhi, 0);
        chk("total_after_clear", total_cnt, 0);
        chk("drop_after_clear", drop_flag, mdl_drop);
    endtask

    task automatic clear_op(input bit with_dump, input bit inject);
        wen_cgr = 0;
        clear = 1;
        dump_start = with_dump;
        tick;
        clear = 0;
        dump_start = 0;
        chk("clear_entry_busy", busy, 1);
        wait_clear(inject);
    endtask

    initial begin
        int vc;
        mdl_reset();
        addr = 0; out_ready = 0;
        // reset must win over every request at the same edge
        RST = 1; wen_cgr = 1; clear = 1; dump_start = 1;
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_total", total_cnt, 0);
        chk("rst_drop", drop_flag, 0);
        RST = 0; wen_cgr = 0; clear = 0; dump_start = 0;
        tick;

        // alternating hits on cell 0x24, then a full-speed dump
        for (int i = 0; i < 5; i++) begin
            wen_cgr = (i % 2 == 0);
            addr    = 6'h24;
            if (wen_cgr) mdl_inc(36);
            tick;
        end
        wen_cgr = 0;
        tick;
        tick;
        chk("bc_total", total_cnt, mdl_tot);
        run_dump(0, 0, vc);
        chk("bc_dump_cycles", vc, 64);

        // stalled every other cycle
        run_dump(1, 0, vc);
        chk("toggle_dump_cycles", vc, 128);

        // random traffic, dumps with random backpressure and dropped requests
        for (int r = 0; r < 4; r++) begin
            incs($urandom_range(20, 200), -1, 60);
            run_dump(2, 1, vc);
        end
        incs(300, 7, 100);
        run_dump(2, 0, vc);

        // clear with simultaneous dump_start selects the sweep
        clear_op(1, 1);
        run_dump(0, 0, vc);

        // clear abort in the middle of a dump
        incs(150, -1, 80);
        dump_start = 1;
        tick;
        dump_start = 0;
        out_ready = 1;
        for (int i = 0; i < 5; i++) tick;
        out_ready = 0;
        clear = 1;
        tick;
        clear = 0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 1);
        wait_clear(0);
        run_dump(2, 0, vc);

        // reset in the middle of a dump
        incs(150, -1, 80);
        dump_start = 1;
        tick;
        dump_start = 0;
        out_ready = 1;
        for (int c = 0; c < 200; c++) begin
            if (out_idx == 6'd20) break;
            tick;
        end
        chk("rst_dump_at_idx", out_idx, 20);
        RST = 1;
        out_ready = 0;
        tick;
        chk("rst_dump_valid", out_valid, 0);
        chk("rst_dump_busy", busy, 0);
        chk("rst_dump_total", total_cnt, 0);
        RST = 0;
        mdl_reset();
        tick;
        run_dump(0, 0, vc);

        // long run on one cell: cell saturates, total keeps counting
        wen_cgr = 1;
        addr = 6'd5;
        for (int i = 0; i < 70000; i++) begin
            mdl_inc(5);
            tick;
        end
        wen_cgr = 0;
        tick;
        tick;
        chk("sat_total", total_cnt, mdl_tot);
        chk("sat_cell_model", mdl_cnt[5], CMAX);
        run_dump(2, 0, vc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
